wb_arbiter_2m: RTL and testbench
================================

// Module: wb_arbiter_2m
// PURPOSE
//  Two-master, one-slave Wishbone (pipelined) arbiter for the user-area peripheral bus.
//  Lets the management-side master and a user-side master share one slave port,
//  e.g. the buttons/LEDs peripheral at 0x3000_0000.
//  Grants are round-robin and whole-cycle: a grant is held until the owning master drops cyc.
//  Slave-side signals are combinationally muxed from the owner, so there is no added data latency.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles without slave ack before a forced release (only with WB_ARB_TIMEOUT_EN); must be >=2
// PORTS
//  clk             in   1   system clock, all state on posedge
//  reset_n         in   1   asynchronous, active-low reset
//  i_mN_wb_cyc     in   1   master N (N=0,1) bus cycle
//  i_mN_wb_stb     in   1   master N strobe
//  i_mN_wb_we      in   1   master N write enable
//  i_mN_wb_addr    in   32  master N address
//  i_mN_wb_data    in   32  master N write data
//  o_mN_wb_ack     out  1   ack to master N
//  o_mN_wb_stall   out  1   stall to master N
//  o_mN_wb_data    out  32  read data to master N
//  o_mN_wb_err     out  1   timeout error to master N (only with WB_ARB_TIMEOUT_EN)
//  o_s_wb_cyc      out  1   slave cycle
//  o_s_wb_stb      out  1   slave strobe
//  o_s_wb_we       out  1   slave write enable
//  o_s_wb_addr     out  32  slave address
//  o_s_wb_data     out  32  slave write data
//  i_s_wb_ack      in   1   slave ack
//  i_s_wb_stall    in   1   slave stall
//  i_s_wb_data     in   32  slave read data
//  o_grant         out  2   one-hot owner: 01=m0, 10=m1, 00=none
// BEHAVIOUR
//  - Registered FSM states: IDLE, GNT0, GNT1. Registered last_grant bit, reset value 1 (m0 wins first tie).
//  - IDLE, one cyc high: go to that master's GNT next cycle.
//  - IDLE, both cyc high: grant !last_grant.
//  - IDLE, neither: stay in IDLE.
//  - GNTn and i_mn_wb_cyc==0: go to IDLE next cycle and set last_grant<=n.
//    This costs one dead cycle between owners, so fairness holds under constant contention.
//  - In IDLE: o_s_wb_cyc/stb/we=0, addr/data=0; both o_mN_wb_stall=1; both acks=0; o_grant=00.
//  - In GNTn, owner n: o_s_wb_* = i_mn_wb_* (cyc, stb, we, addr, data).
//    Owner also gets o_mn_wb_stall=i_s_wb_stall and o_mn_wb_ack=i_s_wb_ack.
//  - In GNTn, the non-owner gets stall=1 and ack=0.
//  - o_mN_wb_data = i_s_wb_data for both masters (unqualified; valid with ack only).
//  - A slave ack arriving in IDLE (owner dropped cyc early) is discarded, never routed.
//  - Master cyc low mid-cycle with an ack outstanding: release proceeds; the late ack is discarded.
//  - Async reset mid-transfer: FSM->IDLE and last_grant->1 immediately; slave cyc/stb fall without a clock.
//  - Reset output values: per the IDLE values above; err=0.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//  - A $clog2(TIMEOUT_CYCLES)+1 bit counter clears on GNT entry and on every i_s_wb_ack.
//  - The counter increments each GNTn cycle without ack.
//  - At count==TIMEOUT_CYCLES-1: o_mn_wb_err=1 for exactly that cycle and slave cyc/stb forced 0 that cycle.
//  - FSM then goes to IDLE with last_grant<=n.
//  - err is never asserted in IDLE or to the non-owner.
//  WB_ARB_TIMEOUT_EN undefined:
//  - No counter, no err ports; a hung slave holds the grant indefinitely.
// TESTING
//  - Reset: assert reset_n=0 with no clock edge.
//    Required: o_grant=00, o_s_wb_cyc=0, both stalls=1, both acks=0.
//  - m0 alone writes 0xA5 to 0x3000_0000 with a 1-cycle-ack slave.
//    Required: o_grant=01 one cycle after cyc; slave sees we=1, data=0xA5; m0 gets ack; m1 stall stays 1.
//  - Both cyc rise together after reset.
//    Required: m0 granted first; after m0 drops cyc, exactly one IDLE cycle, then o_grant=10.
//  - Back-to-back contention over 4 cycles.
//    Required: grants alternate 01,10,01,10; every non-owner ack=0 throughout.
//  - m1 reads 0x3000_0004 with buttons=3'b101.
//    Required: o_m1_wb_data=0x0000_0005 with o_m1_wb_ack=1; o_m0_wb_ack=0.
//  - WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks.
//    Required: o_m0_wb_err pulses 1 cycle on the 16th GNT0 cycle; next cycle o_grant=00.

Source files
------------

// File: rtl/wb_arbiter_2m_if.sv
// Wishbone (pipelined) port bundle used by the two-master arbiter.
// The err member exists only when WB_ARB_TIMEOUT_EN is defined.
interface wb_arbiter_2m_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;
`ifdef WB_ARB_TIMEOUT_EN
  logic        err;
`endif

  // master: the side that starts bus cycles; slave: the side that answers them.
  modport master (
    output cyc, stb, we, addr, wdata,
    input  ack, stall, rdata
`ifdef WB_ARB_TIMEOUT_EN
    , input err
`endif
  );

  modport slave (
    input  cyc, stb, we, addr, wdata,
    output ack, stall, rdata
`ifdef WB_ARB_TIMEOUT_EN
    , output err
`endif
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave pipelined Wishbone arbiter: round-robin, whole-cycle grants.
// Optional slave-ack timeout is enabled with the WB_ARB_TIMEOUT_EN macro.
module wb_arbiter_2m
`ifdef WB_ARB_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 16)
`endif
(
  input  logic                   clk,
  input  logic                   reset_n,
  wb_arbiter_2m_if.slave         m0,
  wb_arbiter_2m_if.slave         m1,
  wb_arbiter_2m_if.master        s,
  output logic [1:0]             o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   timeout_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Entering a grant always comes from IDLE, where the count is held at zero.
  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && !s.ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; blocking ones here would race with readers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;

    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    m0.ack   = 1'b0;
    m0.stall = 1'b1;
    m0.rdata = s.rdata;
    m1.ack   = 1'b0;
    m1.stall = 1'b1;
    m1.rdata = s.rdata;
`ifdef WB_ARB_TIMEOUT_EN
    m0.err   = 1'b0;
    m1.err   = 1'b0;
`endif
    o_grant  = 2'b00;

    case (state_q)
      IDLE: begin
        // Slave acks seen here belong to an abandoned cycle and are dropped.
        if (m0.cyc && m1.cyc) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (m0.cyc) begin
          state_d = GNT0;
        end else if (m1.cyc) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        o_grant  = 2'b01;
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.addr   = m0.addr;
        s.wdata  = m0.wdata;
        m0.ack   = s.ack;
        m0.stall = s.stall;
        if (timeout_hit) begin
          s.cyc  = 1'b0;
          s.stb  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
          m0.err = 1'b1;
`endif
        end
        if (!m0.cyc || timeout_hit) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end

      GNT1: begin
        o_grant  = 2'b10;
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.addr   = m1.addr;
        s.wdata  = m1.wdata;
        m1.ack   = s.ack;
        m1.stall = s.stall;
        if (timeout_hit) begin
          s.cyc  = 1'b0;
          s.stb  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
          m1.err = 1'b1;
`endif
        end
        if (!m1.cyc || timeout_hit) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m: reset, single-master write/read,
// round-robin contention, discarded acks, async reset, and hung-slave behaviour.
module tb_wb_arbiter_2m;

  logic       clk;
  logic       reset_n;
  logic [1:0] o_grant;

  int total = 0;
  int bad   = 0;

  wb_arbiter_2m_if m0_if ();
  wb_arbiter_2m_if m1_if ();
  wb_arbiter_2m_if s_if ();

  wb_arbiter_2m dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
    .s       (s_if.master),
    .o_grant (o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;

    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
    s_if.ack = 1; s_if.stall = 0; s_if.rdata = '0;
`ifdef WB_ARB_TIMEOUT_EN
    s_if.err = 1'b0;
`endif
    reset_n = 0;

    // Reset with no clock edge yet; a stray slave ack must not leak through.
    #1;
    check("rst_grant", 32'(o_grant), 32'h0);
    check("rst_s_cyc", 32'(s_if.cyc), 32'h0);
    check("rst_m0_stall", 32'(m0_if.stall), 32'h1);
    check("rst_m1_stall", 32'(m1_if.stall), 32'h1);
    check("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    check("rst_m1_ack", 32'(m1_if.ack), 32'h0);
    #1;
    reset_n = 1;
    s_if.ack = 0;

    // m0 alone writes 0xA5 to 0x3000_0000.
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1;
    m0_if.addr = 32'h3000_0000; m0_if.wdata = 32'h0000_00A5;
    #1;
    check("wr_idle_grant", 32'(o_grant), 32'h0);
    check("wr_idle_m0_stall", 32'(m0_if.stall), 32'h1);
    step();
    check("wr_grant", 32'(o_grant), 32'h1);
    check("wr_s_cyc", 32'(s_if.cyc), 32'h1);
    check("wr_s_we", 32'(s_if.we), 32'h1);
    check("wr_s_addr", s_if.addr, 32'h3000_0000);
    check("wr_s_data", s_if.wdata, 32'h0000_00A5);
    check("wr_m0_stall", 32'(m0_if.stall), 32'h0);
    check("wr_m1_stall", 32'(m1_if.stall), 32'h1);
    s_if.ack = 1;
    #1;
    check("wr_m0_ack", 32'(m0_if.ack), 32'h1);
    check("wr_m1_ack", 32'(m1_if.ack), 32'h0);
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0;
    s_if.ack = 0;
    step();
    check("wr_release_grant", 32'(o_grant), 32'h0);

    // m1 reads 0x3000_0004, buttons = 3'b101.
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 0; m1_if.addr = 32'h3000_0004;
    step();
    check("rd_grant", 32'(o_grant), 32'h2);
    check("rd_s_addr", s_if.addr, 32'h3000_0004);
    check("rd_s_we", 32'(s_if.we), 32'h0);
    s_if.rdata = 32'h0000_0005;
    s_if.ack = 1;
    #1;
    check("rd_m1_data", m1_if.rdata, 32'h0000_0005);
    check("rd_m1_ack", 32'(m1_if.ack), 32'h1);
    check("rd_m0_ack", 32'(m0_if.ack), 32'h0);
    check("rd_m0_stall", 32'(m0_if.stall), 32'h1);

    // Async reset mid-transfer: slave cyc/stb fall without a clock edge.
    reset_n = 0;
    #1;
    check("arst_s_cyc", 32'(s_if.cyc), 32'h0);
    check("arst_s_stb", 32'(s_if.stb), 32'h0);
    check("arst_grant", 32'(o_grant), 32'h0);
    check("arst_m1_ack", 32'(m1_if.ack), 32'h0);
    m1_if.cyc = 0; m1_if.stb = 0;
    s_if.rdata = '0;
    #1;
    reset_n = 1;

    // Constant contention from reset: m0 first, then alternation with one IDLE gap.
    // The slave acks continuously, so IDLE cycles also prove stray acks are dropped.
    m0_if.cyc = 1; m0_if.stb = 1;
    m1_if.cyc = 1; m1_if.stb = 1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      check($sformatf("rr%0d_grant", i), 32'(o_grant), 32'(exp_g));
      check($sformatf("rr%0d_m0_ack", i), 32'(m0_if.ack), 32'(exp_g[0]));
      check($sformatf("rr%0d_m1_ack", i), 32'(m1_if.ack), 32'(exp_g[1]));
      if (exp_g == 2'b01) m0_if.cyc = 0; else m1_if.cyc = 0;
      step();
      check($sformatf("rr%0d_gap_grant", i), 32'(o_grant), 32'h0);
      check($sformatf("rr%0d_gap_m0_ack", i), 32'(m0_if.ack), 32'h0);
      check($sformatf("rr%0d_gap_m1_ack", i), 32'(m1_if.ack), 32'h0);
      m0_if.cyc = 1;
      m1_if.cyc = 1;
    end
    m0_if.cyc = 0; m0_if.stb = 0;
    m1_if.cyc = 0; m1_if.stb = 0;
    s_if.ack = 0;
    step();
    check("quiet_grant", 32'(o_grant), 32'h0);

    // Slave that never acks.
    m0_if.cyc = 1; m0_if.stb = 1;
    step();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      check($sformatf("to_cyc%0d_grant", k), 32'(o_grant), 32'h1);
      check($sformatf("to_cyc%0d_err", k), 32'(m0_if.err), 32'h0);
      step();
    end
    check("to_err_m0", 32'(m0_if.err), 32'h1);
    check("to_err_m1", 32'(m1_if.err), 32'h0);
    check("to_s_cyc", 32'(s_if.cyc), 32'h0);
    check("to_s_stb", 32'(s_if.stb), 32'h0);
    check("to_grant_last", 32'(o_grant), 32'h1);
    step();
    check("to_release_grant", 32'(o_grant), 32'h0);
    check("to_release_err", 32'(m0_if.err), 32'h0);
`else
    repeat (20) step();
    check("hung_grant", 32'(o_grant), 32'h1);
    check("hung_s_cyc", 32'(s_if.cyc), 32'h1);
    check("hung_m1_stall", 32'(m1_if.stall), 32'h1);
`endif
    m0_if.cyc = 0; m0_if.stb = 0;
    step();
    step();
    check("end_grant", 32'(o_grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
